mc6800_bus_master: RTL
======================

Name: mc6800_bus_master

Overview:
- Clocked initiator for the 6800-style E/RW bus, the opposite end from the SRAM controller.
- Turns single-word read/write requests from an internal agent (loader, DMA, test sequencer) into correctly phased bus cycles. Drives E, RW, address, write data and the SRAM chip-select decode; captures read data at the falling E edge.
- Sits between the internal request interface and the shared bus feeding sram_controller (its sram_ce, i_RW and i_E inputs).

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 8, data width.
- E_LOW_CYCLES, 4, clocks E is low after a cycle starts (address/RW setup); must be >= 1.
- E_HIGH_CYCLES, 4, clocks E is high (data phase); must be >= 1.
- SRAM_BASE, 16'h0000, SRAM decode base address.
- SRAM_MASK, 16'h8000, decode mask; the cycle is SRAM when (addr & SRAM_MASK) == SRAM_BASE.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous reset, active low.
- i_req  in  1  request strobe; sampled only while idle.
- i_we  in  1  1 = write, 0 = read; sampled with i_req.
- i_addr  in  ADDR_W  request address.
- i_wdata  in  DATA_W  write data.
- o_busy  out  1  cycle in progress.
- o_done  out  1  one-clock completion pulse.
- o_rdata  out  DATA_W  captured read data.
- o_addr  out  ADDR_W  bus address.
- o_RW  out  1  bus RW (1 = read).
- o_E  out  1  bus E strobe.
- o_sram_ce  out  1  SRAM select to sram_controller.
- o_data_out  out  DATA_W  bus write data.
- o_data_oe  out  1  write data output enable.
- i_data_in  in  DATA_W  bus read data.

Behaviour:
- Reset: async assert forces o_E=0, o_RW=1, o_sram_ce=0, o_data_oe=0, o_busy=0, o_done=0, o_addr=0, o_data_out=0, o_rdata=0, state IDLE. This applies at any point, including mid-cycle.
- States: IDLE -> ELOW -> EHIGH -> HOLD -> IDLE.
- IDLE: when i_req=1, the next edge (edge 0) does all of the following:
  - latches i_addr into o_addr and i_wdata into o_data_out;
  - sets o_RW = ~i_we and o_sram_ce = decode(i_addr);
  - sets o_data_oe = i_we and o_busy=1;
  - loads the phase counter and moves to ELOW.
- ELOW: o_E=0 for E_LOW_CYCLES clocks. o_E rises at edge E_LOW_CYCLES.
- EHIGH: o_E=1 for E_HIGH_CYCLES clocks. o_E falls at edge E_LOW_CYCLES+E_HIGH_CYCLES. On a read, i_data_in is captured into o_rdata at that same edge.
- HOLD: one clock with o_E=0. o_addr, o_RW, o_sram_ce and o_data_oe are held (address/data hold after E falls).
- Return to IDLE at edge E_LOW_CYCLES+E_HIGH_CYCLES+1:
  - o_RW=1, o_sram_ce=0, o_data_oe=0, o_busy=0;
  - o_done=1 for exactly one clock;
  - o_addr and o_rdata retain their values.
- Latency from acceptance edge to o_done high: E_LOW_CYCLES+E_HIGH_CYCLES+1 clocks (9 with defaults).
- Back-to-back: i_req is sampled in the o_done cycle (IDLE). A held i_req starts the next cycle at the following edge, giving one idle clock with RW=1 and E=0 between cycles.
- i_req while busy is ignored, not queued. i_we/i_addr/i_wdata changes while busy have no effect.
- o_RW and o_sram_ce never change while o_E=1. o_E never rises in the same clock in which o_RW changes.
- Phase counter width is clog2(max(E_LOW_CYCLES,E_HIGH_CYCLES))+1. It counts down to 1 and reloads on each phase entry.

Optional Feature:
- Macro: MC6800_BUS_MRDY_EN.
- Defined: adds input i_mrdy (1 bit). In the last EHIGH clock, if i_mrdy=0, EHIGH is extended one clock at a time until i_mrdy=1; read capture and the E fall occur at the first edge with i_mrdy=1. Latency grows by the number of stretch clocks.
- Undefined: port absent; timing fixed as above.

Test Plan:
- Reset: hold i_rst_n=0 with i_req=1 -> o_E=0, o_RW=1, o_sram_ce=0, o_busy=0, o_done=0, no cycle starts until release.
- Write: i_req=1, i_we=1, i_addr=16'h0010, i_wdata=8'hA5 -> o_sram_ce=1, o_RW=0, o_data_out=A5/o_data_oe=1 from edge 0; o_E high edges 4..8; o_done pulse after edge 9; RW=1 after.
- Read: i_we=0, i_addr=16'h0020, i_data_in=8'h3C during E high (changed to 8'hFF after edge 8) -> o_RW=1, o_rdata=8'h3C, o_done after edge 9.
- Decode: read at i_addr=16'h8000 -> o_sram_ce=0 for the whole cycle, E/RW timing unchanged.
- Back-to-back and mid-cycle reset: i_req held high -> new cycle accepted in the o_done cycle, one idle clock between E pulses; then assert i_rst_n=0 during E high -> o_E=0 immediately, o_RW=1, o_data_oe=0, state IDLE.
- MRDY (MC6800_BUS_MRDY_EN): read with i_mrdy=0 for 3 clocks at end of E high -> E high 7 clocks, o_rdata captured at release edge, o_done after edge 12.

Source files
------------

// File: rtl/mc6800_bus_master_if.sv
// Request and bus signal bundle for mc6800_bus_master.
// The master modport is the bus master itself; the slave modport is the request
// agent / bus model on the other side.
// Optional macro MC6800_BUS_MRDY_EN adds the i_mrdy stretch input.
interface mc6800_bus_master_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    logic              i_req;
    logic              i_we;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_wdata;
    logic              o_busy;
    logic              o_done;
    logic [DATA_W-1:0] o_rdata;
    logic [ADDR_W-1:0] o_addr;
    logic              o_RW;
    logic              o_E;
    logic              o_sram_ce;
    logic [DATA_W-1:0] o_data_out;
    logic              o_data_oe;
    logic [DATA_W-1:0] i_data_in;
`ifdef MC6800_BUS_MRDY_EN
    logic              i_mrdy;
`endif

    modport master (
`ifdef MC6800_BUS_MRDY_EN
        input  i_mrdy,
`endif
        input  i_req,
        input  i_we,
        input  i_addr,
        input  i_wdata,
        input  i_data_in,
        output o_busy,
        output o_done,
        output o_rdata,
        output o_addr,
        output o_RW,
        output o_E,
        output o_sram_ce,
        output o_data_out,
        output o_data_oe
    );

    modport slave (
`ifdef MC6800_BUS_MRDY_EN
        output i_mrdy,
`endif
        output i_req,
        output i_we,
        output i_addr,
        output i_wdata,
        output i_data_in,
        input  o_busy,
        input  o_done,
        input  o_rdata,
        input  o_addr,
        input  o_RW,
        input  o_E,
        input  o_sram_ce,
        input  o_data_out,
        input  o_data_oe
    );
endinterface

// File: rtl/mc6800_bus_master.sv
// 6800-style E/RW bus initiator. Turns single-word read/write requests into a
// phased bus cycle: E low setup, E high data phase, one hold clock, done pulse.
// Optional macro MC6800_BUS_MRDY_EN: i_mrdy low in the last E-high clock
// stretches E high until i_mrdy returns high.
module mc6800_bus_master #(
    parameter int unsigned       ADDR_W        = 16,
    parameter int unsigned       DATA_W        = 8,
    parameter int unsigned       E_LOW_CYCLES  = 4,
    parameter int unsigned       E_HIGH_CYCLES = 4,
    parameter logic [ADDR_W-1:0] SRAM_BASE     = '0,
    parameter logic [ADDR_W-1:0] SRAM_MASK     = {1'b1, {(ADDR_W-1){1'b0}}}
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    mc6800_bus_master_if.master bus
);

    localparam int unsigned CntMax = (E_LOW_CYCLES > E_HIGH_CYCLES) ? E_LOW_CYCLES
                                                                    : E_HIGH_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax) + 1;

    localparam logic [CntW-1:0] LowLoad  = CntW'(E_LOW_CYCLES);
    localparam logic [CntW-1:0] HighLoad = CntW'(E_HIGH_CYCLES);
    localparam logic [CntW-1:0] CntLast  = CntW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StElow,
        StEhigh,
        StHold
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            ehigh_stall;
    logic            sram_hit;

    // Slave-requested stretch of the final E-high clock.
`ifdef MC6800_BUS_MRDY_EN
    assign ehigh_stall = ~bus.i_mrdy;
`else
    assign ehigh_stall = 1'b0;
`endif

    // SRAM chip-select decode of the incoming request address.
    assign sram_hit = ((bus.i_addr & SRAM_MASK) == SRAM_BASE);

    // Bus cycle sequencer; all bus outputs are registered here.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            bus.o_E         <= 1'b0;
            bus.o_RW        <= 1'b1;
            bus.o_sram_ce   <= 1'b0;
            bus.o_data_oe   <= 1'b0;
            bus.o_busy      <= 1'b0;
            bus.o_done      <= 1'b0;
            bus.o_addr      <= '0;
            bus.o_data_out  <= '0;
            bus.o_rdata     <= '0;
        end else begin
            bus.o_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.i_req) begin
                        bus.o_addr     <= bus.i_addr;
                        bus.o_data_out <= bus.i_wdata;
                        bus.o_RW       <= ~bus.i_we;
                        bus.o_sram_ce  <= sram_hit;
                        bus.o_data_oe  <= bus.i_we;
                        bus.o_busy     <= 1'b1;
                        cnt_q          <= LowLoad;
                        state_q        <= StElow;
                    end
                end
                StElow: begin
                    if (cnt_q == CntLast) begin
                        bus.o_E <= 1'b1;
                        cnt_q   <= HighLoad;
                        state_q <= StEhigh;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StEhigh: begin
                    if (cnt_q != CntLast) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (!ehigh_stall) begin
                        // Read data is taken on the same edge that drops E.
                        if (bus.o_RW) begin
                            bus.o_rdata <= bus.i_data_in;
                        end
                        bus.o_E <= 1'b0;
                        state_q <= StHold;
                    end
                end
                StHold: begin
                    // Address, RW and data were held one clock past the E fall.
                    bus.o_RW      <= 1'b1;
                    bus.o_sram_ce <= 1'b0;
                    bus.o_data_oe <= 1'b0;
                    bus.o_busy    <= 1'b0;
                    bus.o_done    <= 1'b1;
                    state_q       <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
